uart_rx_param: RTL and testbench

Parametrised UART receiver for the UART subsystem. It samples an asynchronous serial line with an oversampling clock and supports 5 to `DATA_MAX` data bits, none/even/odd parity, and 1 or 2 stop bits. Each received word is delivered through a valid/ready holding register together with its per-word parity and framing flags, plus a sticky overrun flag. It sits between the line pad and the UART's RX FIFO or register bank.

---
 rtl/uart_rx_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width,
// parity and stop bits. The received word sits in a one-deep valid/ready
// holding register with per-word parity/framing flags and a sticky overrun.
// Optional feature macro: UART_RX_BREAK_EN (break detection on all-zero frames).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for an armed falling edge on rx_s; latches frame config
// S_START | half-bit wait, then confirms the start bit (or false start)
// S_DATA  | samples data bits at bit centre, LSB first
// S_PARITY| samples the parity bit (only when parity is enabled)
// S_STOP  | samples one or two stop bits, then commits or flags break
module uart_rx_param #(
   parameter int DATA_MAX    = 9,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_rx,
   input  logic                reset,
   input  logic                rx,
   input  logic [3:0]          data_bits,
   input  logic [1:0]          par,
   input  logic                stop_bits,
   output logic [DATA_MAX-1:0] dout,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic                par_err,
   output logic                frame_err,
   output logic                overrun,
   output logic                break_det,
   output logic                busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_BREAK_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [3:0]             nbits_q, nbits_d;
   logic [1:0]             par_q, par_d;
   logic                   stop2_q, stop2_d;
   logic                   stop_idx_q, stop_idx_d;
   logic [DATA_MAX-1:0]    shreg_q, shreg_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   zero_q, zero_d;
   logic                   armed_q, armed_d;
   logic [DATA_MAX-1:0]    dout_q, dout_d;
   logic                   dout_valid_q, dout_valid_d;
   logic                   par_err_q, par_err_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;
   logic                   break_q, break_d;
   logic                   busy_q, busy_d;

   logic                   rx_s;
   logic [3:0]             nbits_in;
   logic                   par_en;
   logic                   frame_done;
   logic                   ferr_fin;
   logic                   brk_raw;
   logic                   is_break;
   logic                   hs;

   assign rx_s   = sync_q[SYNC_STAGES-1];
   assign par_en = (par_q == 2'b01) || (par_q == 2'b10);

   // Clamp the requested data width into 5..DATA_MAX before latching it.
   always_comb begin
      nbits_in = data_bits;
      if (data_bits < 4'd5)
         nbits_in = 4'd5;
      else if (data_bits > 4'(DATA_MAX))
         nbits_in = 4'(DATA_MAX);
   end

   // Next-state logic for the synchroniser, frame FSM and holding register.
   always_comb begin
      state_d      = state_q;
      sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      nbits_d      = nbits_q;
      par_d        = par_q;
      stop2_d      = stop2_q;
      stop_idx_d   = stop_idx_q;
      shreg_d      = shreg_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      zero_d       = zero_q;
      armed_d      = armed_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      par_err_d    = par_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      frame_done   = 1'b0;
      ferr_fin     = ferr_q;
      brk_raw      = 1'b0;
      is_break     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (armed_q && !rx_s) begin
               state_d = S_START;
               armed_d = 1'b0;
               nbits_d = nbits_in;
               par_d   = par;
               stop2_d = stop_bits;
            end else if (rx_s) begin
               armed_d = 1'b1;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d    = S_DATA;
                  bit_cnt_d  = '0;
                  shreg_d    = '0;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
                  zero_d     = 1'b1;
                  stop_idx_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d  = '0;
               zero_d = zero_q & ~rx_s;
               for (int i = 0; i < DATA_MAX; i++) begin
                  if (bit_cnt_q == 4'(i))
                     shreg_d[i] = rx_s;
               end
               if (bit_cnt_q == nbits_q - 4'd1)
                  state_d = par_en ? S_PARITY : S_STOP;
               else
                  bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               zero_d  = zero_q & ~rx_s;
               // shreg_q holds only the latched bits, upper bits are zero
               if (par_q == 2'b01)
                  perr_d = (rx_s != ^shreg_q);
               else
                  perr_d = (rx_s != ~^shreg_q);
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d    = '0;
               ferr_fin = ferr_q | ~rx_s;
               ferr_d   = ferr_fin;
               if (!stop_idx_q)
                  zero_d = zero_q & ~rx_s;
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  // a break needs the first stop sample low as well
                  brk_raw    = zero_q & (stop_idx_q | ~rx_s);
                  is_break   = BRK_EN & brk_raw;
                  frame_done = ~is_break;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      hs = dout_valid_q & dout_ready;
      if (hs) begin
         dout_valid_d = 1'b0;
         overrun_d    = 1'b0;
      end
      if (frame_done) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = shreg_q;
            par_err_d    = perr_q;
            frame_err_d  = ferr_fin;
            dout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      break_d = is_break;
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers; the synchroniser resets to the idle level.
   always_ff @(posedge clk_rx or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sync_q       <= '1;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         nbits_q      <= 4'd5;
         par_q        <= 2'b00;
         stop2_q      <= 1'b0;
         stop_idx_q   <= 1'b0;
         shreg_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         zero_q       <= 1'b0;
         armed_q      <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         break_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         nbits_q      <= nbits_d;
         par_q        <= par_d;
         stop2_q      <= stop2_d;
         stop_idx_q   <= stop_idx_d;
         shreg_q      <= shreg_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         zero_q       <= zero_d;
         armed_q      <= armed_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         par_err_q    <= par_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         break_q      <= break_d;
         busy_q       <= busy_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign par_err    = par_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign break_det  = break_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: fixed vector table, hand-written corner-case
// sequences and random frames checked against a frame-level model.
module tb_uart_rx_param;

   localparam int BIT_T = 16;
`ifdef UART_RX_BREAK_EN
   localparam bit BRK = 1'b1;
`else
   localparam bit BRK = 1'b0;
`endif

   logic       clk_rx;
   logic       reset;
   logic       rx;
   logic [3:0] data_bits;
   logic [1:0] par;
   logic       stop_bits;
   logic [8:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       par_err;
   logic       frame_err;
   logic       overrun;
   logic       break_det;
   logic       busy;

   uart_rx_param dut (
      .clk_rx     (clk_rx),
      .reset      (reset),
      .rx         (rx),
      .data_bits  (data_bits),
      .par        (par),
      .stop_bits  (stop_bits),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .par_err    (par_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .break_det  (break_det),
      .busy       (busy)
   );

   initial clk_rx = 1'b0;
   always #5 clk_rx = ~clk_rx;

   int checks = 0;
   int errors = 0;
   int break_cnt = 0;
   int valid_cycles = 0;
   bit busy_seen = 1'b0;
   logic [10:0] got_q[$];

   // Watch outputs mid-cycle: words accepted by a handshake, breaks, busy.
   always begin
      @(negedge clk_rx);
      #1;
      if (dout_valid === 1'b1) valid_cycles++;
      if (dout_valid === 1'b1 && dout_ready === 1'b1)
         got_q.push_back({frame_err, par_err, dout});
      if (break_det === 1'b1) break_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_rx);
   endtask

   task automatic bit_out(input logic v);
      rx = v;
      repeat (BIT_T) @(negedge clk_rx);
   endtask

   task automatic send_frame(input int n, input logic [8:0] d, input bit np, input bit pb,
                             input bit two, input bit s1, input bit s2, input bit end_high);
      bit_out(1'b0);
      for (int i = 0; i < n; i++) bit_out(d[i]);
      if (np) bit_out(pb);
      bit_out(s1);
      if (two) bit_out(s2);
      if (end_high) begin
         rx = 1'b1;
         idle(24);
      end
   endtask

   task automatic check_word(input string nm, input logic [8:0] ed, input logic ep,
                             input logic ef, input bit eb, input int b0);
      logic [10:0] w;
      if (eb) begin
         chk({nm, "_brk"}, 32'(break_cnt - b0), 32'd1);
         chk({nm, "_nword"}, 32'(got_q.size()), 32'd0);
      end else begin
         chk({nm, "_nword"}, 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) begin
            w = got_q.pop_front();
            chk({nm, "_dout"}, 32'(w[8:0]), 32'(ed));
            chk({nm, "_perr"}, 32'(w[9]), 32'(ep));
            chk({nm, "_ferr"}, 32'(w[10]), 32'(ef));
         end
         chk({nm, "_nobrk"}, 32'(break_cnt - b0), 32'd0);
      end
      got_q.delete();
   endtask

   // Frame-level model: what a receiver must report for a given line frame.
   typedef struct {
      logic [8:0] dout;
      logic       perr;
      logic       ferr;
      bit         brk;
   } res_t;

   function automatic int clamp_bits(input int b);
      if (b < 5) return 5;
      if (b > 9) return 9;
      return b;
   endfunction

   function automatic res_t model(input int n, input logic [8:0] d, input logic [1:0] p,
                                  input bit pb, input bit two, input bit s1, input bit s2);
      res_t r;
      int   ones;
      bit   has_par;
      bit   want;
      r.dout  = 9'(d & ((1 << n) - 1));
      ones    = $countones(r.dout);
      has_par = (p == 2'd1) || (p == 2'd2);
      want    = (p == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0);
      r.perr  = has_par && (pb != want);
      r.ferr  = !s1 || (two && !s2);
      r.brk   = BRK && (r.dout == 0) && (!has_par || !pb) && !s1;
      return r;
   endfunction

   typedef struct {
      logic [3:0] cfg;
      logic [1:0] p;
      bit         two;
      int         n;
      bit         np;
      logic [8:0] d;
      bit         pb;
      bit         s1;
      bit         s2;
      logic [8:0] e_dout;
      logic       e_perr;
      logic       e_ferr;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int   b0;
      int   v0;
      res_t r;

      tbl[0] = '{4'd8,  2'd0, 1'b0, 8, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
      tbl[1] = '{4'd7,  2'd1, 1'b0, 7, 1'b1, 9'h041, 1'b1, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
      tbl[2] = '{4'd7,  2'd1, 1'b0, 7, 1'b1, 9'h041, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
      tbl[3] = '{4'd8,  2'd0, 1'b1, 8, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b1};
      tbl[4] = '{4'd9,  2'd2, 1'b0, 9, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0};
      tbl[5] = '{4'd3,  2'd0, 1'b0, 5, 1'b0, 9'h015, 1'b0, 1'b1, 1'b1, 9'h015, 1'b0, 1'b0};
      tbl[6] = '{4'd15, 2'd3, 1'b0, 9, 1'b0, 9'h155, 1'b0, 1'b1, 1'b1, 9'h155, 1'b0, 1'b0};
      tbl[7] = '{4'd6,  2'd2, 1'b0, 6, 1'b1, 9'h02A, 1'b1, 1'b1, 1'b1, 9'h02A, 1'b1, 1'b0};
      tbl[8] = '{4'd5,  2'd1, 1'b1, 5, 1'b1, 9'h01F, 1'b1, 1'b0, 1'b1, 9'h01F, 1'b0, 1'b1};

      reset = 1'b1; rx = 1'b1; data_bits = 4'd8; par = 2'd0; stop_bits = 1'b0;
      dout_ready = 1'b1;
      idle(3);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_perr", 32'(par_err), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_break", 32'(break_det), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      idle(10);
      got_q.delete();

      // table vectors
      for (int i = 0; i < 9; i++) begin
         data_bits = tbl[i].cfg; par = tbl[i].p; stop_bits = tbl[i].two;
         idle(1);
         b0 = break_cnt; v0 = valid_cycles;
         send_frame(tbl[i].n, tbl[i].d, tbl[i].np, tbl[i].pb, tbl[i].two,
                    tbl[i].s1, tbl[i].s2, 1'b1);
         check_word($sformatf("tbl%0d", i), tbl[i].e_dout, tbl[i].e_perr, tbl[i].e_ferr, 1'b0, b0);
         chk($sformatf("tbl%0d_vcycles", i), 32'(valid_cycles - v0), 32'd1);
      end

      // 8N2 with low second stop: no re-arm while the line stays low
      data_bits = 4'd8; par = 2'd0; stop_bits = 1'b1;
      idle(1);
      b0 = break_cnt;
      send_frame(8, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(4);
      busy_seen = 1'b0;
      idle(48);
      chk("rearm_busy_low", 32'(busy_seen), 32'd0);
      rx = 1'b1;
      idle(24);
      check_word("n2_ferr", 9'h03C, 1'b0, 1'b1, 1'b0, b0);
      stop_bits = 1'b0;
      b0 = break_cnt;
      send_frame(8, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_word("rearm_rx", 9'h05A, 1'b0, 1'b0, 1'b0, b0);

      // overrun: two frames without a consumer
      dout_ready = 1'b0;
      send_frame(8, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_frame(8, 9'h022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("ovr_dout", 32'(dout), 32'h011);
      chk("ovr_valid", 32'(dout_valid), 32'd1);
      chk("ovr_flag", 32'(overrun), 32'd1);
      dout_ready = 1'b1;
      idle(1);
      dout_ready = 1'b0;
      #2;
      chk("ovr_hs_valid", 32'(dout_valid), 32'd0);
      chk("ovr_hs_flag", 32'(overrun), 32'd0);
      chk("ovr_hs_word", 32'(got_q.size()), 32'd1);
      got_q.delete();
      dout_ready = 1'b1;
      idle(4);

      // short low glitch: false start, then a 9O1 frame
      busy_seen = 1'b0;
      b0 = break_cnt;
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      chk("glitch_busy", 32'(busy_seen), 32'd1);
      chk("glitch_nword", 32'(got_q.size()), 32'd0);
      data_bits = 4'd9; par = 2'd2;
      send_frame(9, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_word("glitch_next", 9'h1FF, 1'b0, 1'b0, 1'b0, b0);

      // line held low for 12 bit times
      data_bits = 4'd8; par = 2'd0; stop_bits = 1'b0;
      idle(1);
      b0 = break_cnt;
      rx = 1'b0;
      idle(12 * BIT_T);
      rx = 1'b1;
      idle(40);
      check_word("break", 9'h000, 1'b0, 1'b1, BRK, b0);

      // reset in the middle of a frame with a word held
      dout_ready = 1'b0;
      send_frame(8, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mid_pre_valid", 32'(dout_valid), 32'd1);
      rx = 1'b0;
      idle(BIT_T);
      rx = 1'b1;
      idle(20);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(dout_valid), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      idle(3);
      reset = 1'b0;
      dout_ready = 1'b1;
      idle(300);
      chk("mid_rst_nword", 32'(got_q.size()), 32'd0);
      chk("mid_rst_idle", 32'(busy), 32'd0);
      got_q.delete();

      // random frames against the model
      for (int k = 0; k < 25; k++) begin
         logic [3:0] cfg;
         logic [1:0] p;
         logic [8:0] d;
         bit         two, np, pb, s1, s2;
         int         n;
         cfg = 4'($urandom_range(0, 15));
         p   = 2'($urandom_range(0, 3));
         two = 1'($urandom_range(0, 1));
         d   = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
         pb  = 1'($urandom_range(0, 1));
         s1  = ($urandom_range(0, 3) != 0);
         s2  = ($urandom_range(0, 3) != 0);
         n   = clamp_bits(int'(cfg));
         np  = (p == 2'd1) || (p == 2'd2);
         data_bits = cfg; par = p; stop_bits = two;
         idle(1);
         r  = model(n, d, p, pb, two, s1, s2);
         b0 = break_cnt;
         send_frame(n, d, np, pb, two, s1, s2, 1'b1);
         check_word($sformatf("rnd%0d", k), r.dout, r.perr, r.ferr, r.brk, b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
